dii_worm_mux_n: RTL and testbench
=================================

// Module: dii_worm_mux_n
// PURPOSE
// N-input wormhole multiplexer for the DII debug interconnect: merges NUM_IN
// packet streams onto one output, never interleaving flits of different worms.
// Generalises the 2-input ring/local mux: parametrised input count and width,
// fixed-priority or round-robin arbitration, and an optional output register.
// Used in ring routers and as a concentrator in front of shared endpoints.
// PARAMETERS
// NUM_IN   2   number of input channels (1..16)
// WIDTH    16  flit data width in bits
// ARB_MODE 1   0 = fixed priority (lowest index wins), 1 = round robin
// OUT_REG  0   0 = combinational data path, 1 = 2-entry output buffer
// PORTS
// clk        in   1              clock
// rst        in   1              reset, synchronous, active-high
// in_valid   in   NUM_IN         per-input flit valid
// in_first   in   NUM_IN         per-input first-flit marker
// in_last    in   NUM_IN         per-input last-flit marker
// in_data    in   NUM_IN*WIDTH   flit data; input i at [i*WIDTH +: WIDTH]
// in_ready   out  NUM_IN         per-input ready (at most one bit set)
// out_valid  out  1              output flit valid
// out_first  out  1              output first marker
// out_last   out  1              output last marker
// out_data   out  WIDTH          output flit data
// out_ready  in   1              downstream ready
// grant      out  $clog2(NUM_IN) index of current or last owner (min width 1)
// busy       out  1              1 while a worm is locked (state LOCK)
// BEHAVIOUR
// - Reset: state IDLE, grant 0, rr pointer 0, buffer empty; out_valid 0,
//   in_ready 0, busy 0; out_first/out_last/out_data are 0 whenever out_valid is 0.
// - Transfer on valid & ready, on each side independently.
// - Candidates in IDLE: inputs with in_valid & in_first. A valid head flit
//   without first is never granted in IDLE; its in_ready stays 0.
// - ARB_MODE 0: lowest candidate index wins. ARB_MODE 1: first candidate at or
//   after rr pointer (wrapping NUM_IN-1 -> 0). Pointer <- owner+1 (mod NUM_IN)
//   when the owner's last flit is accepted; no other event moves it.
// - FSM IDLE: a winner is selected and forwarded in the same cycle.
//   If its flit is accepted and in_last is 1 -> stay IDLE.
//   Otherwise -> LOCK with owner = winner (lock on presentation).
//   out_valid never drops and its flit never changes until accepted.
// - FSM LOCK: only owner connected; in_ready[owner] follows the path ready;
//   other in_ready are 0. Owner in_valid low -> out_valid low (bubble), still
//   locked. Accepted owner flit with in_last=1 -> IDLE. A first=1 flit seen
//   in LOCK is forwarded as-is; no error checking.
// - OUT_REG 0: zero latency; in_ready[owner] = out_ready.
//   OUT_REG 1: 2-entry FIFO between mux and output, 1-cycle latency, full
//   throughput. in_ready[owner] = !full. out_* are driven from the FIFO head.
//   The worm-done transition keys on the input-side acceptance of last.
// - Simultaneous: in the cycle a last flit is accepted, no new grant is made.
//   The next worm starts in the following cycle (1-cycle gap, both modes).
// - rst mid-worm: FSM to IDLE and buffer flushed next edge. Partial worm is
//   dropped; upstream is responsible for resync.
// TESTING
// 1 Reset, all in_valid=0 -> out_valid=0, in_ready=0, busy=0, grant=0.
// 2 NUM_IN=4, ARB_MODE=1, all four send 1-flit worms continuously, out_ready=1
//   -> grant order 0,1,2,3,0. One worm per 2 cycles (gap cycle).
// 3 Input 2 sends 3-flit worm, input 0 valid/first from cycle 1 -> out carries
//   2,2,2 then 0. in_ready[0]=0 until after input-2 last.
// 4 out_ready=0 with first flit presented by input 1, input 0 raises first next
//   cycle -> out_data stays input-1 flit, grant stays 1 until accepted.
// 5 ARB_MODE=0, inputs 1 and 3 always requesting -> input 1 wins every time.
//   Input 3 starves, as specified.
// 6 OUT_REG=1, 5-flit worm, out_ready toggling 1,0,1,0 -> all 5 flits in order.
//   No loss/dup, first latency 1 cycle. Assert rst mid-worm -> out_valid=0 next cycle.

Source files
------------

// File: rtl/dii_worm_mux_n.sv
// rtl/dii_worm_mux_n.sv - N-input wormhole mux for the DII debug interconnect
module dii_worm_mux_n #(
    parameter int NUM_IN   = 2,
    parameter int WIDTH    = 16,
    parameter int ARB_MODE = 1,
    parameter int OUT_REG  = 0,
    localparam int GW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN-1:0]       in_first,
    input  logic [NUM_IN-1:0]       in_last,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic                    out_first,
    output logic                    out_last,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic [GW-1:0]           grant,
    output logic                    busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]              state;
    logic [GW-1:0]           owner;
    logic [GW-1:0]           rr_ptr;
    logic                    gap;

    logic [NUM_IN-1:0]       cand;
    logic [NUM_IN-1:0]       cand_sh;
    logic                    win_found;
    logic [GW-1:0]           win_idx;
    int                      idx;

    logic                    sel_on;
    logic [GW-1:0]           sel_idx;
    logic [NUM_IN-1:0]       valid_sh;
    logic [NUM_IN-1:0]       first_sh;
    logic [NUM_IN-1:0]       last_sh;
    logic [NUM_IN*WIDTH-1:0] data_sh;
    logic                    mux_valid;
    logic                    mux_first;
    logic                    mux_last;
    logic [WIDTH-1:0]        mux_data;
    logic                    path_ready;
    logic                    accept;
    logic                    worm_done;
    logic [GW-1:0]           next_ptr;

    always_comb begin
        cand      = in_valid & in_first;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand_sh   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx     = (ARB_MODE == 0) ? k : (int'(rr_ptr) + k) % NUM_IN;
            cand_sh = cand >> idx;
            if (!win_found && cand_sh[0]) begin
                win_found = 1'b1;
                win_idx   = GW'(idx);
            end
        end
    end

    // A new grant is held off for one cycle after any last flit is taken.
    always_comb begin
        sel_on  = 1'b0;
        sel_idx = owner;
        if (!rst) begin
            if (state == ST_LOCK) begin
                sel_on  = 1'b1;
                sel_idx = owner;
            end else if (!gap && win_found) begin
                sel_on  = 1'b1;
                sel_idx = win_idx;
            end
        end
    end

    always_comb begin
        valid_sh  = in_valid >> sel_idx;
        first_sh  = in_first >> sel_idx;
        last_sh   = in_last >> sel_idx;
        data_sh   = in_data >> (int'(sel_idx) * WIDTH);
        mux_valid = sel_on & valid_sh[0];
        mux_first = first_sh[0];
        mux_last  = last_sh[0];
        mux_data  = data_sh[WIDTH-1:0];
        accept    = mux_valid & path_ready;
        worm_done = accept & mux_last;
        in_ready  = '0;
        if (sel_on && path_ready) begin
            in_ready[sel_idx] = 1'b1;
        end
    end

    assign next_ptr = (sel_idx == GW'(NUM_IN - 1)) ? '0 : sel_idx + 1'b1;
    assign grant    = sel_on ? sel_idx : owner;
    assign busy     = (state == ST_LOCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            gap    <= 1'b0;
        end else begin
            gap <= worm_done;
            if (sel_on) begin
                owner <= sel_idx;
            end
            if (worm_done) begin
                rr_ptr <= next_ptr;
            end
            case (state)
                ST_IDLE: if (sel_on && !worm_done) state <= ST_LOCK;
                ST_LOCK: if (worm_done) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    generate
        if (OUT_REG == 0) begin : g_comb
            assign path_ready = out_ready;
            assign out_valid  = mux_valid;
            assign out_first  = mux_valid & mux_first;
            assign out_last   = mux_valid & mux_last;
            assign out_data   = mux_valid ? mux_data : '0;
        end else begin : g_reg
            logic [WIDTH+1:0] mem [2];
            logic             wr_ptr;
            logic             rd_ptr;
            logic [1:0]       count;
            logic             push;
            logic             pop;
            logic [WIDTH+1:0] head;

            assign push       = accept;
            assign pop        = (count != 2'd0) & out_ready;
            assign path_ready = (count != 2'd2);
            assign head       = mem[rd_ptr];
            assign out_valid  = (count != 2'd0);
            assign out_first  = out_valid & head[WIDTH+1];
            assign out_last   = out_valid & head[WIDTH];
            assign out_data   = out_valid ? head[WIDTH-1:0] : '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr <= 1'b0;
                    rd_ptr <= 1'b0;
                    count  <= 2'd0;
                end else begin
                    if (push) begin
                        mem[wr_ptr] <= {mux_first, mux_last, mux_data};
                        wr_ptr      <= ~wr_ptr;
                    end
                    if (pop) begin
                        rd_ptr <= ~rd_ptr;
                    end
                    count <= count + {1'b0, push} - {1'b0, pop};
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dii_worm_mux_n.sv
// tb/tb_dii_worm_mux_n.sv - randomized bench for dii_worm_mux_n against a worm-level model
module tb_dii_worm_mux_n;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int ND = 3;
    localparam int GW = 2;

    typedef struct packed {
        logic         first;
        logic         last;
        logic [W-1:0] data;
    } flit_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ND-1:0][N-1:0]   in_valid, in_first, in_last, in_ready;
    logic [ND-1:0][N*W-1:0] in_data;
    logic [ND-1:0]          out_valid, out_first, out_last, out_ready, busy;
    logic [ND-1:0][W-1:0]   out_data;
    logic [ND-1:0][GW-1:0]  grant;

    dii_worm_mux_n #(.NUM_IN(N), .WIDTH(W), .ARB_MODE(1), .OUT_REG(0)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_first(in_first[0]),
        .in_last(in_last[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
        .out_valid(out_valid[0]), .out_first(out_first[0]), .out_last(out_last[0]),
        .out_data(out_data[0]), .out_ready(out_ready[0]), .grant(grant[0]), .busy(busy[0]));

    dii_worm_mux_n #(.NUM_IN(N), .WIDTH(W), .ARB_MODE(0), .OUT_REG(0)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_first(in_first[1]),
        .in_last(in_last[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
        .out_valid(out_valid[1]), .out_first(out_first[1]), .out_last(out_last[1]),
        .out_data(out_data[1]), .out_ready(out_ready[1]), .grant(grant[1]), .busy(busy[1]));

    dii_worm_mux_n #(.NUM_IN(N), .WIDTH(W), .ARB_MODE(1), .OUT_REG(1)) u_reg (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_first(in_first[2]),
        .in_last(in_last[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
        .out_valid(out_valid[2]), .out_first(out_first[2]), .out_last(out_last[2]),
        .out_data(out_data[2]), .out_ready(out_ready[2]), .grant(grant[2]), .busy(busy[2]));

    int n_cmp = 0;
    int n_bad = 0;
    int n_print = 0;
    int cyc = 0;
    int phase = 0;

    // model: owner -1 means no worm in flight
    int    m_owner [ND];
    int    m_lgrant[ND];
    int    m_rr    [ND];
    bit    m_gap   [ND];
    int    m_acc   [ND];
    flit_t m_fifo  [$];

    int           s_len [ND][N];
    int           s_pos [ND][N];
    bit           s_pres[ND][N];
    logic [W-1:0] s_data[ND][N];

    int       p_valid, p_ready, min_len, max_len;
    bit       use_src, ready_toggle;
    logic [N-1:0] src_mask;

    int rr_seen, rr_last_cyc, fp_cnt1, fp_cnt3;
    int exp_rr_order[5] = '{0, 1, 2, 3, 0};

    function automatic int arbm(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    function automatic int oreg(input int d);
        return (d == 2) ? 1 : 0;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
            end
        end
    endtask

    function automatic int pick(input int d);
        logic [N-1:0] c;
        int i;
        c = in_valid[d] & in_first[d];
        for (int k = 0; k < N; k++) begin
            i = (arbm(d) == 1) ? (m_rr[d] + k) % N : k;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_owner[d]  = -1;
            m_lgrant[d] = 0;
            m_rr[d]     = 0;
            m_gap[d]    = 1'b0;
            m_acc[d]    = -1;
            for (int i = 0; i < N; i++) begin
                s_len[d][i]  = 0;
                s_pos[d][i]  = 0;
                s_pres[d][i] = 1'b0;
            end
        end
        m_fifo.delete();
    endtask

    task automatic model_eval(input int d);
        int           sel, eg;
        bit           pr, mv, ev, ef, el;
        logic [W-1:0] ed;
        logic [N-1:0] er;
        flit_t        f;
        pr  = (oreg(d) == 1) ? (m_fifo.size() < 2) : out_ready[d];
        sel = -1;
        if (m_owner[d] >= 0) sel = m_owner[d];
        else if (!m_gap[d]) sel = pick(d);
        er = '0;
        mv = 1'b0;
        f  = '0;
        if (sel >= 0) begin
            if (pr) er[sel] = 1'b1;
            mv      = in_valid[d][sel];
            f.first = in_first[d][sel];
            f.last  = in_last[d][sel];
            f.data  = in_data[d][sel*W +: W];
        end
        eg = (sel >= 0) ? sel : m_lgrant[d];
        ev = 1'b0; ef = 1'b0; el = 1'b0; ed = '0;
        if (oreg(d) == 0) begin
            if (mv) begin ev = 1'b1; ef = f.first; el = f.last; ed = f.data; end
        end else if (m_fifo.size() > 0) begin
            ev = 1'b1; ef = m_fifo[0].first; el = m_fifo[0].last; ed = m_fifo[0].data;
        end
        check_eq($sformatf("d%0d out_valid", d), out_valid[d], ev);
        check_eq($sformatf("d%0d out_first", d), out_first[d], ef);
        check_eq($sformatf("d%0d out_last", d), out_last[d], el);
        check_eq($sformatf("d%0d out_data", d), out_data[d], ed);
        check_eq($sformatf("d%0d in_ready", d), in_ready[d], er);
        check_eq($sformatf("d%0d grant", d), grant[d], eg);
        check_eq($sformatf("d%0d busy", d), busy[d], m_owner[d] >= 0);
        m_acc[d] = (mv && pr) ? sel : -1;
        if (oreg(d) == 1) begin
            if (ev && out_ready[d]) void'(m_fifo.pop_front());
            if (mv && pr) m_fifo.push_back(f);
        end
        if (mv && pr && f.last) begin
            m_owner[d] = -1;
            m_gap[d]   = 1'b1;
            m_rr[d]    = (sel + 1) % N;
        end else begin
            m_gap[d] = 1'b0;
            if (sel >= 0) m_owner[d] = sel;
        end
        if (sel >= 0) m_lgrant[d] = sel;
    endtask

    task automatic drive();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < N; i++) begin
                if (src_mask[i] && !s_pres[d][i] && ($urandom_range(99) < p_valid)) begin
                    if (s_len[d][i] == 0) begin
                        s_len[d][i] = $urandom_range(max_len, min_len);
                        s_pos[d][i] = 0;
                    end
                    s_pres[d][i] = 1'b1;
                    s_data[d][i] = W'($urandom);
                end
                in_valid[d][i] = s_pres[d][i];
                in_first[d][i] = s_pres[d][i] && (s_pos[d][i] == 0);
                in_last[d][i]  = s_pres[d][i] && (s_pos[d][i] == s_len[d][i] - 1);
                in_data[d][i*W +: W] = s_pres[d][i] ? s_data[d][i] : W'($urandom);
            end
            out_ready[d] = ready_toggle ? (cyc % 2 == 0) : ($urandom_range(99) < p_ready);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < ND; d++) model_eval(d);
            if (phase == 2 && out_valid[0] && rr_seen < 5) begin
                check_eq("rr grant order", grant[0], exp_rr_order[rr_seen]);
                if (rr_seen > 0) check_eq("rr worm spacing", cyc - rr_last_cyc, 2);
                rr_last_cyc = cyc;
                rr_seen++;
            end
            if (phase == 5 && out_valid[1]) begin
                if (grant[1] == 2'd1) fp_cnt1++;
                if (grant[1] == 2'd3) fp_cnt3++;
            end
            if (use_src) begin
                for (int d = 0; d < ND; d++) begin
                    for (int i = 0; i < N; i++) begin
                        if (s_pres[d][i] && m_acc[d] == i) begin
                            s_pres[d][i] = 1'b0;
                            s_pos[d][i]++;
                            if (s_pos[d][i] == s_len[d][i]) s_len[d][i] = 0;
                        end
                    end
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive();
            step();
        end
    endtask

    task automatic src_reset();
        rst = 1'b1;
        drive();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        use_src = 1'b0; ready_toggle = 1'b0; src_mask = '1;
        p_valid = 0; p_ready = 100; min_len = 1; max_len = 1;
        in_valid = '0; in_first = '0; in_last = '0; in_data = '0; out_ready = '1;
        model_reset();
        @(posedge clk); #1;

        phase = 1;
        step();
        rst = 1'b0;
        step();
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("reset d%0d out_valid", d), out_valid[d], 1'b0);
            check_eq($sformatf("reset d%0d in_ready", d), in_ready[d], '0);
            check_eq($sformatf("reset d%0d busy", d), busy[d], 1'b0);
            check_eq($sformatf("reset d%0d grant", d), grant[d], '0);
        end

        phase = 2;
        use_src = 1'b1; p_valid = 100; p_ready = 100; min_len = 1; max_len = 1;
        rr_seen = 0; rr_last_cyc = 0;
        src_reset();
        run(12);
        check_eq("rr worms seen", rr_seen, 5);

        phase = 3;
        p_valid = 60; p_ready = 70; min_len = 1; max_len = 4;
        run(600);

        phase = 4;
        p_valid = 80; p_ready = 25; max_len = 3;
        run(400);

        phase = 5;
        src_mask = 4'b1010; p_valid = 100; p_ready = 100; max_len = 3;
        fp_cnt1 = 0; fp_cnt3 = 0;
        src_reset();
        run(60);
        check_eq("fp input3 starved", fp_cnt3, 0);
        check_eq("fp input1 served", fp_cnt1 > 20, 1'b1);

        phase = 6;
        src_mask = '1; min_len = 5; max_len = 5; ready_toggle = 1'b1;
        src_reset();
        run(13);
        rst = 1'b1;
        drive();
        step();
        rst = 1'b0;
        check_eq("reg flush after rst", out_valid[2], 1'b0);
        run(40);
        ready_toggle = 1'b0;

        phase = 7;
        use_src = 1'b0;
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            in_valid[d] = 4'b0100; in_first[d] = '0; in_last[d] = 4'b0100;
            in_data[d] = {N*W{1'b1}}; out_ready[d] = 1'b1;
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("nofirst in_ready", in_ready[1], '0);
            check_eq("nofirst out_valid", out_valid[1], 1'b0);
        end
        for (int d = 0; d < ND; d++) in_first[d] = 4'b0100;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
